div_issue: RTL

Issue front-end for the modular divider (a·b⁻¹ mod p, p = 2^31−1). It accepts raw 32-bit operand pairs over a valid/ready handshake and reduces them mod p. It rejects divisor ≡ 0 without engaging the divider, sequences the divider's start/ready protocol, and returns the quotient with a tag and latency count over a second valid/ready handshake. It handles one operation in flight and sits between the ALU dispatch logic and the divider.

---
 rtl/div_issue.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/div_issue.sv
// div_issue: issue front-end for the mod-(2^31-1) divider.
// Accepts raw 32-bit operand pairs, reduces them mod p, short-circuits a zero
// divisor, sequences the divider start/ready protocol and returns the quotient
// with its tag and the start-to-capture latency.
module div_issue #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             div_start,
  output logic [30:0]      div_a,
  output logic [30:0]      div_b,
  input  logic [30:0]      div_result,
  input  logic             div_rdy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [30:0]      out_q,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [15:0]      out_cycles
);

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] a_raw;
  logic [31:0] b_raw;
  logic [30:0] ra;
  logic [30:0] rb;
  logic [15:0] lat_cnt;
  logic [15:0] lat_inc;

  // Fold a 32-bit value into [0, p-1] for p = 2^31-1 using 2^31 == 1 mod p.
  function automatic logic [30:0] reduce_p(input logic [31:0] x);
    logic [31:0] s;
    logic [30:0] t;
    s = {1'b0, x[30:0]} + {31'd0, x[31]};
    // s[31] set implies s[30:0] == 0, so this second fold cannot overflow.
    t = s[30:0] + {30'd0, s[31]};
    if (t == '1) begin
      reduce_p = '0;
    end else begin
      reduce_p = t;
    end
  endfunction

  // Reduced operands, valid combinationally while in REDUCE.
  always_comb begin
    ra = reduce_p(a_raw);
    rb = reduce_p(b_raw);
  end

  // Saturating latency increment.
  always_comb begin
    lat_inc = (lat_cnt == '1) ? lat_cnt : lat_cnt + 16'd1;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = REDUCE;
      REDUCE:  state_next = (rb == '0) ? HOLD : ISSUE;
      ISSUE:   if (div_rdy) state_next = WAIT;
      WAIT:    if (div_rdy) state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and divider-start outputs decoded from state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == HOLD);
    div_start = (state == ISSUE) && div_rdy;
  end

  // Operand, divider-operand, result and latency registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_raw      <= '0;
      b_raw      <= '0;
      div_a      <= '0;
      div_b      <= '0;
      out_q      <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
      out_cycles <= '0;
      lat_cnt    <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        a_raw   <= in_a;
        b_raw   <= in_b;
        out_tag <= in_tag;
      end
      if (state == REDUCE) begin
        div_a <= ra;
        div_b <= rb;
        if (rb == '0) begin
          out_err    <= 1'b1;
          out_q      <= '0;
          out_cycles <= '0;
        end
      end
      if (state == ISSUE && div_rdy) begin
        lat_cnt <= '0;
      end
      // The captured count includes the capture cycle itself, so a result
      // ready in the first WAIT cycle reports 1.
      if (state == WAIT) begin
        lat_cnt <= lat_inc;
        if (div_rdy) begin
          out_q      <= div_result;
          out_cycles <= lat_inc;
          out_err    <= 1'b0;
        end
      end
    end
  end

endmodule
